signature_compactor: RTL and testbench
======================================

SIGNATURE_COMPACTOR -- requirements
Module: signature_compactor

Interface
REQ-001 Parameter: TERMINAL_COUNT, 8'hFF, stimulus value that ends a capture window.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a capture window; sampled on clk.
REQ-005 Port: seed  input  8  exam-dependent seed mixed into every update.
REQ-006 Port: pc, ir, pm_address, from_PS, from_ID, from_CU  input  8 each  processor observation buses.
REQ-007 Port: x0, x1, y0, y1, r, m, o_reg  input  4 each  processor register observations.
REQ-008 Port: zero_flag  input  1  processor zero flag.
REQ-009 Port: stim  output  8  stimulus counter; stim[7:4] drives processor i_pins.
REQ-010 Port: signature  output  16  accumulated answer code.
REQ-011 Port: busy  output  1  high while in RUN.
REQ-012 Port: done  output  1  high while in DONE; signature is final.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE, all registered on clk.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL move to RUN and clear stim and signature to 0 at that edge.
REQ-015 In RUN, start SHALL be ignored.
REQ-016 Scramble value SHALL be seed ^ {m,o_reg} ^ {x1,x0} ^ {y1,y0} ^ {3'b0,zero_flag,r} ^ ir ^ pc ^ pm_address ^ from_PS ^ from_ID ^ from_CU, combinational from current inputs.
REQ-017 sum SHALL be (signature[7:0] + scramble) mod 256; carry discarded.
REQ-018 At each RUN edge with stim != TERMINAL_COUNT: signature <= {signature[14:8], sum, signature[15]}; stim <= stim + 1.
REQ-019 At a RUN edge with stim == TERMINAL_COUNT: signature and stim SHALL hold, state SHALL move to DONE.
REQ-020 Window timing: start sampled at edge k gives updates at edges k+1..k+TERMINAL_COUNT and done=1 after edge k+TERMINAL_COUNT+1.
REQ-021 In IDLE and DONE, signature and stim SHALL hold their values.
REQ-022 busy SHALL equal (state==RUN) and done SHALL equal (state==DONE), decoded from registered state with no combinational path from start.
REQ-023 stim SHALL never wrap past TERMINAL_COUNT inside a window.
REQ-024 If TERMINAL_COUNT=0, RUN SHALL last exactly one cycle with no update.
REQ-025 start asserted on the same edge as the terminal count in RUN SHALL be ignored; the next start, from DONE, restarts the window.

Reset
REQ-026 reset=1 at an edge SHALL force state IDLE, stim=8'h00, signature=16'h0000, busy=0 and done=0, overriding start.
REQ-027 reset mid-RUN SHALL abort the window, with no partial done indication.

Verification
REQ-028 Zero path: all inputs 0, start pulse -> signature stays 16'h0000, busy high 256 cycles, done rises 256 edges after start, stim ends 8'hFF.
REQ-029 Seed only: seed=8'h01, others 0 -> signature 16'h0002, 16'h0006, 16'h000E after updates 1, 2, 3.
REQ-030 Rotation wrap: force signature[15]=1 by a seed sequence -> bit 0 of next signature equals prior bit 15; carry out of sum is dropped.
REQ-031 Reset at update 100 of a window -> next edge stim=0, signature=0, IDLE, done=0; a later start gives the full 255-update result identical to the zero-path check.
REQ-032 start held high continuously -> one window, done for one cycle, immediate restart with stim and signature cleared.
REQ-033 Restart from DONE with seed=8'hFF -> signature matches a bit-exact reference model of REQ-016..REQ-019 over the whole window.

Source files
------------

// File: rtl/signature_compactor.sv
// Signature compactor: steps a stimulus counter through one capture window
// and folds the processor observation buses into a rotating 16-bit signature.
module signature_compactor #(
    parameter logic [7:0] TERMINAL_COUNT = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  seed,
    input  logic [7:0]  pc,
    input  logic [7:0]  ir,
    input  logic [7:0]  pm_address,
    input  logic [7:0]  from_PS,
    input  logic [7:0]  from_ID,
    input  logic [7:0]  from_CU,
    input  logic [3:0]  x0,
    input  logic [3:0]  x1,
    input  logic [3:0]  y0,
    input  logic [3:0]  y1,
    input  logic [3:0]  r,
    input  logic [3:0]  m,
    input  logic [3:0]  o_reg,
    input  logic        zero_flag,
    output logic [7:0]  stim,
    output logic [15:0] signature,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  stim_q, stim_d;
    logic [15:0] sig_q, sig_d;
    logic [7:0]  scramble;
    logic [7:0]  sum;

    // XOR-fold every observation bus with the seed; the adder drops its carry.
    always_comb begin
        scramble = seed ^ {m, o_reg} ^ {x1, x0} ^ {y1, y0}
                 ^ {3'b000, zero_flag, r} ^ ir ^ pc ^ pm_address
                 ^ from_PS ^ from_ID ^ from_CU;
        sum      = sig_q[7:0] + scramble;
    end

    // Window control: start only honoured outside RUN; terminal edge freezes.
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        sig_d   = sig_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    stim_d  = 8'h00;
                    sig_d   = 16'h0000;
                end
            end
            RUN: begin
                if (stim_q == TERMINAL_COUNT) begin
                    state_d = DONE;
                end else begin
                    stim_d = stim_q + 8'd1;
                    sig_d  = {sig_q[14:8], sum, sig_q[15]};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stim_q  <= 8'h00;
            sig_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            sig_q   <= sig_d;
        end
    end

    // Status decoded from registered state only.
    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        stim      = stim_q;
        signature = sig_q;
    end

endmodule

// File: tb/tb_signature_compactor.sv
// Directed bench for signature_compactor: hand-computed vectors plus a small
// reference model for the long windows.
module tb_signature_compactor;

    logic        clk = 1'b0;
    logic        reset, start, zero_flag;
    logic [7:0]  seed, pc, ir, pm_address, from_PS, from_ID, from_CU;
    logic [3:0]  x0, x1, y0, y1, r, m, o_reg;
    logic [7:0]  stim, stim0;
    logic [15:0] signature, signature0;
    logic        busy, done, busy0, done0;

    int n_checks = 0;
    int n_pass   = 0;
    int n;
    logic [15:0] msig;

    always #5 clk = ~clk;

    signature_compactor dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .pc(pc), .ir(ir), .pm_address(pm_address),
        .from_PS(from_PS), .from_ID(from_ID), .from_CU(from_CU),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .m(m), .o_reg(o_reg),
        .zero_flag(zero_flag), .stim(stim), .signature(signature),
        .busy(busy), .done(done)
    );

    signature_compactor #(.TERMINAL_COUNT(8'h00)) dut0 (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .pc(pc), .ir(ir), .pm_address(pm_address),
        .from_PS(from_PS), .from_ID(from_ID), .from_CU(from_CU),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .m(m), .o_reg(o_reg),
        .zero_flag(zero_flag), .stim(stim0), .signature(signature0),
        .busy(busy0), .done(done0)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        seed = 0; pc = 0; ir = 0; pm_address = 0;
        from_PS = 0; from_ID = 0; from_CU = 0;
        x0 = 0; x1 = 0; y0 = 0; y1 = 0; r = 0; m = 0; o_reg = 0;
        zero_flag = 0;
    endtask

    task automatic rand_obs();
        pc = 8'($urandom); ir = 8'($urandom); pm_address = 8'($urandom);
        from_PS = 8'($urandom); from_ID = 8'($urandom);
        from_CU = 8'($urandom);
        x0 = 4'($urandom); x1 = 4'($urandom); y0 = 4'($urandom);
        y1 = 4'($urandom); r = 4'($urandom); m = 4'($urandom);
        o_reg = 4'($urandom); zero_flag = 1'($urandom);
    endtask

    function automatic logic [7:0] scr();
        return seed ^ {m, o_reg} ^ {x1, x0} ^ {y1, y0}
             ^ {3'b000, zero_flag, r} ^ ir ^ pc ^ pm_address
             ^ from_PS ^ from_ID ^ from_CU;
    endfunction

    function automatic logic [15:0] upd(input logic [15:0] s,
                                         input logic [7:0] sc);
        logic [7:0] sm;
        sm = s[7:0] + sc;
        return {s[14:8], sm, s[15]};
    endfunction

    task automatic wait_done(input int limit, output int cnt);
        cnt = 0;
        while (!done && cnt < limit) begin
            tick();
            cnt++;
        end
        check("wait_done", 32'(done), 32'd1);
    endtask

    initial begin
        zero_inputs();
        reset = 1'b1;
        start = 1'b1;
        tick();
        check("rst_stim", 32'(stim), 32'h00);
        check("rst_sig", 32'(signature), 32'h0000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // seed only
        seed  = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("seed_busy", 32'(busy), 32'd1);
        check("seed_stim0", 32'(stim), 32'h00);
        tick();
        check("seed_u1", 32'(signature), 32'h0002);
        check("tc0_done", 32'(done0), 32'd1);
        check("tc0_busy", 32'(busy0), 32'd0);
        check("tc0_sig", 32'(signature0), 32'h0000);
        tick();
        check("seed_u2", 32'(signature), 32'h0006);
        tick();
        check("seed_u3", 32'(signature), 32'h000E);
        check("seed_stim3", 32'(stim), 32'h03);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // rotation wrap and dropped carry
        zero_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        seed = 8'h80;
        tick();
        check("rot_u1", 32'(signature), 32'h0100);
        seed = 8'h00;
        for (int i = 0; i < 7; i++) tick();
        check("rot_u8", 32'(signature), 32'h8000);
        seed = 8'hFF;
        tick();
        check("rot_wrap", 32'(signature), 32'h01FF);
        seed = 8'h02;
        tick();
        check("rot_carry", 32'(signature), 32'h0202);
        check("rot_stim", 32'(stim), 32'd10);

        // reset at update 100
        seed = 8'h5A;
        for (int i = 0; i < 89; i++) tick();
        check("pre_rst_stim", 32'(stim), 32'd99);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_stim", 32'(stim), 32'h00);
        check("abort_sig", 32'(signature), 32'h0000);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);

        // zero path, with a start pulse mid-window
        zero_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zp_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 50; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zp_ign_stim", 32'(stim), 32'd51);
        check("zp_ign_busy", 32'(busy), 32'd1);
        wait_done(400, n);
        check("zp_len", 32'(n + 51), 32'd256);
        check("zp_sig", 32'(signature), 32'h0000);
        check("zp_stim", 32'(stim), 32'hFF);
        check("zp_busy_end", 32'(busy), 32'd0);

        // start held high
        seed  = 8'h01;
        start = 1'b1;
        tick();
        check("hold_stim0", 32'(stim), 32'h00);
        check("hold_sig0", 32'(signature), 32'h0000);
        msig = 16'h0000;
        for (int i = 0; i < 255; i++) begin
            msig = upd(msig, scr());
            tick();
        end
        check("hold_sig", 32'(signature), 32'(msig));
        check("hold_stim", 32'(stim), 32'hFF);
        check("hold_busy", 32'(busy), 32'd1);
        tick();
        check("hold_done", 32'(done), 32'd1);
        check("hold_sig_keep", 32'(signature), 32'(msig));
        tick();
        check("hold_rs_done", 32'(done), 32'd0);
        check("hold_rs_busy", 32'(busy), 32'd1);
        check("hold_rs_stim", 32'(stim), 32'h00);
        check("hold_rs_sig", 32'(signature), 32'h0000);
        start = 1'b0;
        wait_done(400, n);
        check("hold_len", 32'(n), 32'd256);

        // restart from DONE with seed FF against model
        seed = 8'hFF;
        rand_obs();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ref_stim0", 32'(stim), 32'h00);
        check("ref_sig0", 32'(signature), 32'h0000);
        msig = 16'h0000;
        for (int i = 0; i < 255; i++) begin
            rand_obs();
            msig = upd(msig, scr());
            tick();
            check("ref_sig", 32'(signature), 32'(msig));
        end
        check("ref_stim", 32'(stim), 32'hFF);
        rand_obs();
        tick();
        check("ref_done", 32'(done), 32'd1);
        check("ref_sig_end", 32'(signature), 32'(msig));
        rand_obs();
        tick();
        check("ref_sig_hold", 32'(signature), 32'(msig));
        check("ref_stim_hold", 32'(stim), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
